johnson_counter_param: RTL
==========================

Name: johnson_counter_param

Overview:
- Parametrised N-bit Johnson (twisted-ring) counter; successor to the fixed 4-bit Johnson counter.
- Adds count enable, up/down direction, parallel load with legality sanitising, a registered state index and a wrap pulse.
- Used as a low-glitch sequencer or phase generator inside sequential designs. The state index lets downstream logic use the state without its own decoder.

Parameters:
- WIDTH, 4, number of ring bits; legal range 2..16; sequence length is 2*WIDTH states.
- IDX_W, $clog2(2*WIDTH), width of state_idx; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; advances one state per clock when high.
- dir  input  1  1 = forward sequence, 0 = reverse sequence.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- dout  output  WIDTH  registered ring state.
- state_idx  output  IDX_W  registered position of dout in the sequence, range 0..2*WIDTH-1.
- wrap  output  1  registered one-cycle pulse on a sequence wrap.
- load_err  output  1  registered one-cycle pulse when load_val was illegal.

Behaviour:
- Everything is evaluated on the rising edge of clk. Priority order: reset > load > en.
- reset=1: dout=0, state_idx=0, wrap=0, load_err=0. Reset asserted mid-count takes effect on that edge. The first count after reset release gives dout=...0001.
- Forward step (en=1, dir=1): dout <= {dout[WIDTH-2:0], ~dout[WIDTH-1]}; state_idx <= (state_idx+1) mod 2*WIDTH.
  - WIDTH=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then back to 0000.
- Reverse step (en=1, dir=0): dout <= {~dout[0], dout[WIDTH-1:1]}; state_idx <= (state_idx-1) mod 2*WIDTH. This walks the same sequence backwards.
- en=0 with load=0: dout and state_idx hold; wrap=0, load_err=0.
- wrap=1 for exactly one cycle in either of these cases, otherwise 0:
  - the forward step from index 2*WIDTH-1 to 0;
  - the reverse step from index 0 to 2*WIDTH-1.
- Legal value: of the form 0..01..1 (including all-zero) or 1..10..0 (including all-one). Exactly 2*WIDTH legal values exist.
- Load of a legal value:
  - dout <= load_val.
  - state_idx <= popcount(load_val) if load_val[WIDTH-1]=0, else 2*WIDTH - popcount(load_val).
  - wrap=0, load_err=0.
- Load of an illegal value: dout <= 0, state_idx <= 0, load_err=1 for one cycle, wrap=0.
- load=1 overrides en and dir in the same cycle; no counting occurs on a load edge.
- Invariant: after reset, dout is always a legal value and always matches state_idx. Direction may change on any cycle with no dead cycle.

Optional Feature:
- Macro: JOHNSON_DECODE_EN.
- Defined:
  - adds output port dec (output, 2*WIDTH bits), a one-hot decode of the current state;
  - dec[state_idx]=1 and all other bits are 0;
  - registered and updated on the same edge as dout; reset value 0...01.
- Undefined:
  - port dec and its logic are absent;
  - all other behaviour is identical.

Test Plan (WIDTH=4):
- Reset held 2 cycles, then en=1, dir=1 for 9 clocks -> dout steps 0001,0011,0111,1111,1110,1100,1000,0000,0001; state_idx 1..7,0,1; wrap=1 only on the cycle dout returns to 0000.
- From dout=0000, en=1, dir=0 for 3 clocks -> dout 1000,1100,1110; state_idx 7,6,5; wrap=1 on the first step only.
- load=1, load_val=1100 -> dout=1100, state_idx=6, load_err=0. Then load_val=0101 -> dout=0000, state_idx=0, load_err pulse of one cycle.
- At dout=0111, assert load=1 (load_val=1110) and en=1 together -> dout=1110, state_idx=5, no extra step. Then en=0 for 3 cycles -> dout holds at 1110.
- Mid-count at dout=1110, assert reset with en=1 -> dout=0000, state_idx=0, wrap=0 on that edge. Release reset -> next edge dout=0001.
- With JOHNSON_DECODE_EN defined, run 8 forward steps -> dec walks 00000010 through 10000000 to 00000001, always one-hot and always equal to 1<<state_idx.

Source files
------------

// File: rtl/johnson_counter_param.sv
`default_nettype none
// ============================================================================
// Module   : johnson_counter_param
// Purpose  : N-bit Johnson (twisted-ring) counter with enable, up/down
//            direction, sanitised parallel load, state index and wrap pulse.
//            Optional one-hot state decode output enabled by the macro
//            JOHNSON_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] dout,
    output logic [IDX_W-1:0] state_idx,
    output logic             wrap,
    output logic             load_err
`ifdef JOHNSON_DECODE_EN
    ,
    output logic [2*WIDTH-1:0] dec
`endif
);

    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(2*WIDTH-1);

    logic [WIDTH-1:0] r_dout;
    logic [IDX_W-1:0] r_idx;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_inv;
    logic [WIDTH-1:0] w_val_p1;
    logic [WIDTH-1:0] w_inv_p1;
    logic [IDX_W-1:0] w_pop;
    logic             w_legal;
    logic [WIDTH-1:0] w_dout_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_wrap_nxt;
    logic             w_err_nxt;

    // A value is legal when it (or its complement) is a low-aligned run of ones.
    assign w_inv    = ~load_val;
    assign w_val_p1 = load_val + c_ONE;
    assign w_inv_p1 = w_inv + c_ONE;
    assign w_legal  = ((load_val & w_val_p1) == '0) || ((w_inv & w_inv_p1) == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + IDX_W'(load_val[i]);
        end
    end

    always_comb begin
        w_dout_nxt = r_dout;
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (load) begin
            if (w_legal) begin
                w_dout_nxt = load_val;
                // 2*WIDTH - pop, written so 2*WIDTH never has to fit in IDX_W
                w_idx_nxt  = load_val[WIDTH-1] ? (c_IDX_LAST - w_pop + c_IDX_ONE) : w_pop;
            end else begin
                w_dout_nxt = '0;
                w_idx_nxt  = '0;
                w_err_nxt  = 1'b1;
            end
        end else if (en) begin
            if (dir) begin
                w_dout_nxt = {r_dout[WIDTH-2:0], ~r_dout[WIDTH-1]};
                w_wrap_nxt = (r_idx == c_IDX_LAST);
                w_idx_nxt  = w_wrap_nxt ? '0 : (r_idx + c_IDX_ONE);
            end else begin
                w_dout_nxt = {~r_dout[0], r_dout[WIDTH-1:1]};
                w_wrap_nxt = (r_idx == '0);
                w_idx_nxt  = w_wrap_nxt ? c_IDX_LAST : (r_idx - c_IDX_ONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_dout <= w_dout_nxt;
            r_idx  <= w_idx_nxt;
            r_wrap <= w_wrap_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign dout      = r_dout;
    assign state_idx = r_idx;
    assign wrap      = r_wrap;
    assign load_err  = r_err;

`ifdef JOHNSON_DECODE_EN
    localparam logic [2*WIDTH-1:0] c_DEC_ONE = (2*WIDTH)'(1);

    logic [2*WIDTH-1:0] r_dec;

    // Decoded from the next index so it lands on the same edge as dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec <= c_DEC_ONE;
        end else begin
            r_dec <= c_DEC_ONE << w_idx_nxt;
        end
    end

    assign dec = r_dec;
`endif

endmodule
`default_nettype wire
